// File: rtl/syn_branch_resolver.sv
// Execute-stage branch resolver: queues fetch predictions, checks them at EX and drives fetch/BHT correction.
// Optional BR_STATS_EN adds saturating branch / mispredict counters (stat_br, stat_miss).
module syn_branch_resolver #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 8,
    parameter int FLUSH_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              f_valid,
    input  logic [ADDR_W-1:0] f_pc,
    input  logic [ADDR_W-1:0] f_pred,
    output logic              q_full,
    input  logic              r_valid,
    input  logic [ADDR_W-1:0] r_pc,
    input  logic              r_isbj,
    input  logic              r_taken,
    input  logic [ADDR_W-1:0] r_target,
    output logic              succeed,
    output logic              gone,
    output logic [ADDR_W-1:0] g_addr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [ADDR_W-1:0] pc_before_g,
    output logic              isbj,
    output logic              flush,
    output logic              err,
    output logic              dbg_state
`ifdef BR_STATS_EN
    ,
    output logic [31:0]       stat_br,
    output logic [31:0]       stat_miss
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC + 1) : 1;
    localparam logic [PTR_W:0]  PTR_ONE  = (PTR_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {ST_NORMAL = 1'b0, ST_RECOVER = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_q_pc   [DEPTH];
    logic [ADDR_W-1:0] r_q_pred [DEPTH];
    logic [PTR_W:0]    r_wr_ptr, r_rd_ptr;

    logic              w_empty, w_accept, w_pop, w_mispredict, w_push, w_drop, w_err_set;
    logic [ADDR_W-1:0] w_head_pc, w_head_pred, w_s_addr, w_actual;

    // Handshake: fetch pushes whenever f_valid is high and q_full is low (or a pop frees a slot
    // this cycle); a resolution is taken on r_valid in NORMAL with no back-pressure.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign q_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_head_pc   = r_q_pc[r_rd_ptr[PTR_W-1:0]];
    assign w_head_pred = r_q_pred[r_rd_ptr[PTR_W-1:0]];
    assign w_s_addr    = r_pc + ADDR_W'(1);
    assign w_actual    = (r_isbj && r_taken) ? r_target : w_s_addr;
    assign dbg_state   = r_state;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_NORMAL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; the counter only advances on enabled cycles
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (en) begin
            case (r_state)
                ST_NORMAL: begin
                    if (w_mispredict) begin
                        w_state_nxt = ST_RECOVER;
                        w_cnt_nxt   = CNT_W'(FLUSH_CYC);
                    end
                end
                ST_RECOVER: begin
                    if (r_cnt <= CNT_ONE) begin
                        w_state_nxt = ST_NORMAL;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                default: w_state_nxt = ST_NORMAL;
            endcase
        end
    end

    // Output/decode logic for the current state
    always_comb begin
        w_accept     = en && r_valid && (r_state == ST_NORMAL);
        w_pop        = w_accept && !w_empty;
        w_mispredict = w_pop && (w_actual != w_head_pred);
        w_push       = en && f_valid && (!q_full || w_pop) && !w_mispredict;
        w_drop       = en && f_valid && q_full && !w_pop;
        w_err_set    = (w_accept && w_empty) || (w_pop && (w_head_pc != r_pc)) || w_drop;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr[PTR_W-1:0]]   <= f_pc;
            r_q_pred[r_wr_ptr[PTR_W-1:0]] <= f_pred;
        end
    end

    // A mispredict empties the queue; anything fetched so far is wrong-path
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (en) begin
            if (w_mispredict) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            succeed     <= 1'b1;
            gone        <= 1'b0;
            g_addr      <= '0;
            s_addr      <= '0;
            pc_before_g <= '0;
            isbj        <= 1'b0;
            flush       <= 1'b0;
            err         <= 1'b0;
        end else if (en) begin
            flush <= w_mispredict;
            err   <= err | w_err_set;
            if (w_pop) begin
                succeed     <= !w_mispredict;
                isbj        <= r_isbj;
                gone        <= r_isbj & r_taken;
                g_addr      <= r_target;
                s_addr      <= w_s_addr;
                pc_before_g <= r_pc;
            end else begin
                succeed <= 1'b1;
                isbj    <= 1'b0;
            end
        end
    end

`ifdef BR_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_br   <= '0;
            stat_miss <= '0;
        end else if (en) begin
            if (w_pop && r_isbj && (stat_br != '1))  stat_br   <= stat_br + 32'd1;
            if (w_mispredict && (stat_miss != '1))   stat_miss <= stat_miss + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_syn_branch_resolver.sv
// Bench for syn_branch_resolver: directed scenarios then random traffic, checked against a queue model.
module tb_syn_branch_resolver;
    localparam int AW        = 8;
    localparam int DEPTH     = 8;
    localparam int FLUSH_CYC = 2;

    logic          clk = 1'b0;
    logic          rst_n, en, f_valid, r_valid, r_isbj, r_taken;
    logic [AW-1:0] f_pc, f_pred, r_pc, r_target;
    logic          q_full, succeed, gone, isbj, flush, err, dbg_state;
    logic [AW-1:0] g_addr, s_addr, pc_before_g;
`ifdef BR_STATS_EN
    logic [31:0]   stat_br, stat_miss;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [2*AW-1:0] exp_q[$];
    int              m_ign;
    logic            m_err, m_succeed, m_gone, m_isbj, m_flush;
    logic [AW-1:0]   m_g, m_s, m_pcb;

    always #5 clk = ~clk;

    syn_branch_resolver #(.ADDR_W(AW), .DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .f_valid(f_valid), .f_pc(f_pc), .f_pred(f_pred), .q_full(q_full),
        .r_valid(r_valid), .r_pc(r_pc), .r_isbj(r_isbj), .r_taken(r_taken), .r_target(r_target),
        .succeed(succeed), .gone(gone), .g_addr(g_addr), .s_addr(s_addr),
        .pc_before_g(pc_before_g), .isbj(isbj), .flush(flush), .err(err),
        .dbg_state(dbg_state)
`ifdef BR_STATS_EN
        , .stat_br(stat_br), .stat_miss(stat_miss)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Resolver behaviour in terms of a list of outstanding predictions and a drain countdown
    function automatic void model_step();
        logic [2*AW-1:0] h;
        bit full, resolve, pop, mis;
        int actual;
        if (!rst_n) begin
            exp_q.delete();
            m_ign = 0; m_err = 0; m_succeed = 1; m_gone = 0; m_isbj = 0; m_flush = 0;
            m_g = '0; m_s = '0; m_pcb = '0;
            return;
        end
        if (!en) return;
        full    = (exp_q.size() == DEPTH);
        resolve = r_valid && (m_ign == 0);
        pop     = resolve && (exp_q.size() > 0);
        mis     = 0;
        if (resolve && exp_q.size() == 0) m_err = 1;
        if (pop) begin
            h = exp_q.pop_front();
            if (h[2*AW-1:AW] != r_pc) m_err = 1;
            actual = (r_isbj && r_taken) ? int'(r_target) : (int'(r_pc) + 1) % (1 << AW);
            mis = (actual != int'(h[AW-1:0]));
            m_succeed = !mis;
            m_isbj    = r_isbj;
            m_gone    = r_isbj && r_taken;
            m_g       = r_target;
            m_s       = AW'((int'(r_pc) + 1) % (1 << AW));
            m_pcb     = r_pc;
        end else begin
            m_succeed = 1;
            m_isbj    = 0;
        end
        m_flush = mis;
        if (mis) begin
            exp_q.delete();
            m_ign = (FLUSH_CYC == 0) ? 1 : FLUSH_CYC;
        end else if (m_ign > 0) begin
            m_ign--;
        end
        if (f_valid && !mis) begin
            if (!full || pop) exp_q.push_back({f_pc, f_pred});
            else              m_err = 1;
        end
    endfunction

    task automatic check_all();
        check("succeed",     32'(succeed),     32'(m_succeed));
        check("gone",        32'(gone),        32'(m_gone));
        check("g_addr",      32'(g_addr),      32'(m_g));
        check("s_addr",      32'(s_addr),      32'(m_s));
        check("pc_before_g", 32'(pc_before_g), 32'(m_pcb));
        check("isbj",        32'(isbj),        32'(m_isbj));
        check("flush",       32'(flush),       32'(m_flush));
        check("err",         32'(err),         32'(m_err));
        check("q_full",      32'(q_full),      32'(exp_q.size() == DEPTH));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_push(input bit v, input logic [AW-1:0] pc, input logic [AW-1:0] pred);
        f_valid = v; f_pc = pc; f_pred = pred;
    endtask

    task automatic set_res(input bit v, input logic [AW-1:0] pc, input bit bj, input bit tk,
                           input logic [AW-1:0] tgt);
        r_valid = v; r_pc = pc; r_isbj = bj; r_taken = tk; r_target = tgt;
    endtask

    initial begin
        rst_n = 0; en = 1;
        set_push(1, 8'h05, 8'h06);
        set_res(1, 8'h05, 0, 0, 8'h00);
        @(negedge clk);

        // Reset with push/resolve active
        tick(); tick();
        check("rst_succeed", 32'(succeed), 32'd1);
        check("rst_err",     32'(err),     32'd0);
        rst_n = 1;
        set_push(0, 0, 0); set_res(0, 0, 0, 0, 0);
        tick();

        // Correct prediction, non-branch
        set_push(1, 8'h10, 8'h11); tick();
        set_push(0, 0, 0); set_res(1, 8'h10, 0, 0, 8'h00); tick();
        check("cp_succeed", 32'(succeed), 32'd1);
        check("cp_err",     32'(err),     32'd0);
        set_res(0, 0, 0, 0, 0); tick();

        // Taken branch mispredicted as fall-through
        set_push(1, 8'h20, 8'h21); tick();
        set_push(0, 0, 0); set_res(1, 8'h20, 1, 1, 8'h40); tick();
        check("mp_succeed", 32'(succeed),     32'd0);
        check("mp_g_addr",  32'(g_addr),      32'h40);
        check("mp_s_addr",  32'(s_addr),      32'h21);
        check("mp_pcbg",    32'(pc_before_g), 32'h20);
        check("mp_flush",   32'(flush),       32'd1);
        set_res(1, 8'h33, 1, 0, 8'h00); tick(); tick();
        check("mp_drain_err", 32'(err), 32'd0);
        set_res(0, 0, 0, 0, 0); tick();

        // Fall-through wrap at the top of the address space
        set_push(1, 8'hFF, 8'h00); tick();
        set_push(0, 0, 0); set_res(1, 8'hFF, 1, 0, 8'h12); tick();
        check("wrap_s_addr",  32'(s_addr),  32'h00);
        check("wrap_succeed", 32'(succeed), 32'd1);
        set_res(0, 0, 0, 0, 0); tick();

        // Fill the queue, overflow, then push+pop while full
        for (int i = 0; i < DEPTH; i++) begin
            set_push(1, AW'(8'h30 + i), AW'(8'h31 + i)); tick();
        end
        check("full_q_full", 32'(q_full), 32'd1);
        set_push(1, 8'h50, 8'h51); tick();
        check("ovf_err", 32'(err), 32'd1);
        set_push(1, 8'h52, 8'h53); set_res(1, 8'h30, 0, 0, 8'h00); tick();
        check("pp_q_full", 32'(q_full), 32'd1);
        set_push(0, 0, 0); set_res(0, 0, 0, 0, 0);

        // Recovery countdown frozen while en is low
        rst_n = 0; tick(); rst_n = 1;
        set_push(1, 8'h60, 8'h61); tick();
        set_push(0, 0, 0); set_res(1, 8'h60, 1, 1, 8'h70); tick();
        en = 0; set_push(1, 8'h99, 8'h9A); set_res(1, 8'h11, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) tick();
        en = 1; set_push(1, 8'h80, 8'h81); tick();
        set_push(0, 0, 0); tick();
        check("rec_err", 32'(err), 32'd0);
        set_res(1, 8'h80, 0, 0, 8'h00); tick();
        check("rec_accept_err", 32'(err), 32'd0);
        check("rec_accept_pcbg", 32'(pc_before_g), 32'h80);
        set_res(0, 0, 0, 0, 0); tick();

        // Random traffic
        rst_n = 0; tick(); rst_n = 1;
        for (int c = 0; c < 600; c++) begin
            logic [AW-1:0] pc;
            rst_n = ($urandom_range(0, 149) != 0);
            en    = ($urandom_range(0, 9) != 0);
            pc    = AW'($urandom);
            set_push($urandom_range(0, 1) == 1, pc,
                     ($urandom_range(0, 2) != 0) ? AW'(pc + 1) : AW'($urandom));
            if (exp_q.size() > 0 && $urandom_range(0, 15) != 0)
                set_res($urandom_range(0, 2) == 0, exp_q[0][2*AW-1:AW], $urandom_range(0, 1) == 1,
                        $urandom_range(0, 1) == 1,
                        $urandom_range(0, 1) == 1 ? exp_q[0][AW-1:0] : AW'($urandom));
            else
                set_res($urandom_range(0, 7) == 0, AW'($urandom), $urandom_range(0, 1) == 1,
                        $urandom_range(0, 1) == 1, AW'($urandom));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
